mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store front end between the MIPS CPU datapath and the Avalon-style data RAM. Accepts one CPU memory operation at a time (LB/LBU/LH/LHU/LW/LWL/LWR/SB/SH/SW) and converts it into a single word-aligned bus transaction with byte enables. Honours `avm_waitrequest` and the RAM's one-cycle registered read latency. Returns sign/zero-extended or merged load data to the register-file write-back path.

## Interface
- No parameters; all widths fixed at 32-bit data, 32-bit byte address.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` input 1: sole clock; all state and outputs update on rising edge.
- `reset` input 1: synchronous, active-high.
- `cpu_start` input 1: request strobe, sampled only in IDLE.
- `cpu_op` input 4: opcode. LB=0, LBU=1, LH=2, LHU=3, LW=4, LWL=5, LWR=6, SB=8, SH=9, SW=10. All other values are illegal.
- `cpu_addr` input 32: byte address.
- `cpu_wdata` input 32: store data; for LWL/LWR, the old rt value.
- `cpu_busy` output 1: high whenever state ≠ IDLE.
- `cpu_done` output 1: one-cycle completion pulse.
- `cpu_rdata` output 32: load result, valid while `cpu_done`=1.
- `cpu_err` output 1: misaligned or illegal op, valid while `cpu_done`=1.
- `avm_address` output 32: `{cpu_addr[31:2],2'b00}`.
- `avm_read` output 1: read request.
- `avm_write` output 1: write request.
- `avm_byteenable` output 4: active lanes.
- `avm_writedata` output 32: lane-positioned store data.
- `avm_waitrequest` input 1: slave stall.
- `avm_readdata` input 32: valid in the cycle after read acceptance.

## Operation
- Memory is little-endian. Lane k = byte offset k = bits `[8k+7:8k]`.
- FSM states: IDLE, REQ, RDATA, DONE.
  - IDLE + `cpu_start`: latch op, addr, wdata.
    - Illegal op or misalignment → DONE with err=1, rdata=0, no bus cycle.
    - Misalignment: LH/LHU/SH with `addr[0]`=1; LW/SW with `addr[1:0]`≠0.
    - Otherwise → REQ.
  - REQ: hold `avm_read` or `avm_write`, address, byteenable and writedata stable.
    - While `avm_waitrequest`=1: stay in REQ.
    - When waitrequest=0: write → DONE; read → RDATA.
  - RDATA: sample `avm_readdata`, format it, register the result → DONE.
  - DONE: `cpu_done`=1 for exactly one cycle → IDLE.
- Store lanes:
  - SB: byteenable = 1<<off; byte replicated into all four lanes.
  - SH: byteenable 0011 (off 0) or 1100 (off 2); halfword replicated into both halves.
  - SW: byteenable 1111.
- Load byteenable:
  - LB/LBU: 1<<off. LH/LHU: as SH. LW: 1111. LWL/LWR: 1111.
- Load format:
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - LWL at offset k: `(word << 8*(3-k)) | (rt & ~(32'hFFFFFFFF << 8*(3-k)))`.
  - LWR at offset k: `(word >> 8k) | (rt & ~(32'hFFFFFFFF >> 8k))`.
- `cpu_start` outside IDLE is ignored.
- Reset values: state=IDLE; every output = 0.
- Reset mid-transaction: request is abandoned and `avm_read`/`avm_write` drop the next cycle. No `cpu_done` is issued.

## Timing
- All outputs are registered; no combinational path from input to output.
- `cpu_start` at cycle T: request visible T+1.
- Zero-wait write: accepted T+1, `cpu_done` T+2.
- Zero-wait read: accepted T+1, readdata T+2, `cpu_done`/`cpu_rdata` T+3.
- Each waitrequest cycle adds one cycle.
- Error path: `cpu_done` at T+1, no bus activity.
- Back-to-back: next start is accepted in the IDLE cycle following DONE.

## Configuration
- `MEM_ACCESS_LWLR_EN`
  - Defined: LWL/LWR are supported as above.
  - Undefined: op 5 and op 6 are illegal (err=1, no bus cycle), and the merge logic is absent.

## Structure
- `mem_access_pkg` holds:
  - the `mem_op_t` opcode enum and the `state_t` FSM enum;
  - lane constants `BE_BYTE0`..`BE_WORD`.
- Sub-module `mem_load_format`: purely combinational. Inputs are op, offset, raw word and old rt; output is the formatted result. Instantiated in RDATA.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10, zero wait → write done at T+2; read returns 0xDEADBEEF at T+3, byteenable 1111.
- SB 0x80 @0x23, then LB and LBU @0x23 → byteenable 1000, writedata 0x80808080; LB=0xFFFFFF80, LBU=0x00000080.
- LH @0x22 with word 0x8001xxxx → byteenable 1100; LH=0xFFFF8001, LHU=0x00008001.
- LW @0x12 and SH @0x11 → err=1, done at T+1, `avm_read`/`avm_write` never asserted.
- LW with waitrequest held 3 cycles → request stable for 4 cycles, done at T+6; reset asserted during waitrequest → read drops next cycle, no done.
- (`MEM_ACCESS_LWLR_EN`) word 0x44332211, rt 0xAABBCCDD → LWL @off1 = 0x2211CCDD; LWR @off1 = 0xAA443322.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and lane helpers for the load/store front end (mem_access_unit).
// Optional LWL/LWR support is selected with MEM_ACCESS_LWLR_EN.
package mem_access_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_LWL = 4'd5,
    OP_LWR = 4'd6,
    OP_SB  = 4'd8,
    OP_SH  = 4'd9,
    OP_SW  = 4'd10
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RDATA = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [BE_W-1:0] BE_BYTE0 = 4'b0001;
  localparam logic [BE_W-1:0] BE_BYTE1 = 4'b0010;
  localparam logic [BE_W-1:0] BE_BYTE2 = 4'b0100;
  localparam logic [BE_W-1:0] BE_BYTE3 = 4'b1000;
  localparam logic [BE_W-1:0] BE_HALF0 = 4'b0011;
  localparam logic [BE_W-1:0] BE_HALF1 = 4'b1100;
  localparam logic [BE_W-1:0] BE_WORD  = 4'b1111;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW: op_legal = 1'b1;
`ifdef MEM_ACCESS_LWLR_EN
      OP_LWL, OP_LWR: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    op_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: op_misaligned = off[0];
      OP_LW, OP_SW:         op_misaligned = (off != 2'd0);
      default:              op_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [BE_W-1:0] lane_be(input logic [3:0] op, input logic [1:0] off);
    case (op)
      OP_LB, OP_LBU, OP_SB: begin
        case (off)
          2'd0:    lane_be = BE_BYTE0;
          2'd1:    lane_be = BE_BYTE1;
          2'd2:    lane_be = BE_BYTE2;
          default: lane_be = BE_BYTE3;
        endcase
      end
      OP_LH, OP_LHU, OP_SH: lane_be = off[1] ? BE_HALF1 : BE_HALF0;
      default:              lane_be = BE_WORD;
    endcase
  endfunction

  // Stores replicate the datum so the enabled lane always carries it.
  function automatic logic [DATA_W-1:0] store_lanes(input logic [3:0] op,
                                                    input logic [DATA_W-1:0] wdata);
    case (op)
      OP_SB:   store_lanes = {4{wdata[7:0]}};
      OP_SH:   store_lanes = {2{wdata[15:0]}};
      default: store_lanes = wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_format.sv
// Combinational load formatter: lane extraction, sign/zero extension and LWL/LWR merge.
// LWL/LWR merge exists only when MEM_ACCESS_LWLR_EN is defined.
module mem_load_format
  import mem_access_pkg::*;
(
  input  mem_op_t           op,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] rt,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = 8'(word >> 5'({off, 3'b000}));
  assign half_v = off[1] ? word[31:16] : word[15:0];

`ifdef MEM_ACCESS_LWLR_EN
  logic [4:0] sh_l;
  logic [4:0] sh_r;

  assign sh_l = 5'({2'd3 - off, 3'b000});
  assign sh_r = 5'({off, 3'b000});
`else
  logic unused_rt;
  assign unused_rt = ^rt;
`endif

  always_comb begin
    result = '0;
    case (op)
      OP_LB:  result = {{24{byte_v[7]}}, byte_v};
      OP_LBU: result = {24'd0, byte_v};
      OP_LH:  result = {{16{half_v[15]}}, half_v};
      OP_LHU: result = {16'd0, half_v};
      OP_LW:  result = word;
`ifdef MEM_ACCESS_LWLR_EN
      OP_LWL: result = (word << sh_l) | (rt & ~(32'hFFFF_FFFF << sh_l));
      OP_LWR: result = (word >> sh_r) | (rt & ~(32'hFFFF_FFFF >> sh_r));
`endif
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end: one CPU memory op -> one word-aligned Avalon transaction.
// Define MEM_ACCESS_LWLR_EN to support LWL/LWR; otherwise ops 5/6 report an error.
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_start,
  input  logic [3:0]        cpu_op,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [BE_W-1:0]   avm_byteenable,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata
);

  state_t            state;
  state_t            state_n;
  mem_op_t           op_q;
  logic [1:0]        off_q;
  logic [DATA_W-1:0] rt_q;
  logic              wr_q;

  logic              accept;
  logic              wr_n;
  logic              err_n;
  logic [DATA_W-1:0] rdata_n;
  logic [DATA_W-1:0] load_result;

  mem_load_format u_fmt (
    .op     (op_q),
    .off    (off_q),
    .word   (avm_readdata),
    .rt     (rt_q),
    .result (load_result)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state plus the values the output registers take on this edge.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    wr_n    = wr_q;
    err_n   = 1'b0;
    rdata_n = '0;
    case (state)
      IDLE: begin
        if (cpu_start) begin
          if (!op_legal(cpu_op) || op_misaligned(cpu_op, cpu_addr[1:0])) begin
            state_n = DONE;
            err_n   = 1'b1;
          end else begin
            state_n = REQ;
            accept  = 1'b1;
            wr_n    = op_is_store(cpu_op);
          end
        end
      end
      REQ: begin
        if (!avm_waitrequest) state_n = wr_q ? DONE : RDATA;
      end
      RDATA: begin
        state_n = DONE;
        rdata_n = load_result;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_busy       <= 1'b0;
      cpu_done       <= 1'b0;
      cpu_err        <= 1'b0;
      cpu_rdata      <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_address    <= '0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
      op_q           <= OP_LB;
      off_q          <= 2'd0;
      rt_q           <= '0;
      wr_q           <= 1'b0;
    end else begin
      cpu_busy  <= (state_n != IDLE);
      cpu_done  <= (state_n == DONE);
      cpu_err   <= err_n;
      cpu_rdata <= rdata_n;
      avm_read  <= (state_n == REQ) && !wr_n;
      avm_write <= (state_n == REQ) && wr_n;
      if (accept) begin
        op_q           <= mem_op_t'(cpu_op);
        off_q          <= cpu_addr[1:0];
        rt_q           <= cpu_wdata;
        wr_q           <= wr_n;
        avm_address    <= {cpu_addr[ADDR_W-1:2], 2'b00};
        avm_byteenable <= lane_be(cpu_op, cpu_addr[1:0]);
        avm_writedata  <= store_lanes(cpu_op, cpu_wdata);
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small byte-enabled RAM model.
// Covers LWL/LWR when MEM_ACCESS_LWLR_EN is defined, error path otherwise.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_start;
  logic [3:0]  cpu_op;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_busy;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned bus_seen = 0;
  logic [31:0] mem [0:15];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_start       (cpu_start),
    .cpu_op          (cpu_op),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .cpu_busy        (cpu_busy),
    .cpu_done        (cpu_done),
    .cpu_rdata       (cpu_rdata),
    .cpu_err         (cpu_err),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_byteenable  (avm_byteenable),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata)
  );

  // RAM model: byte-enabled writes, one-cycle registered reads.
  always @(posedge clk) begin
    if (avm_write && !avm_waitrequest) begin
      for (int k = 0; k < 4; k++)
        if (avm_byteenable[k]) mem[avm_address[5:2]][8*k +: 8] <= avm_writedata[8*k +: 8];
    end
    if (avm_read && !avm_waitrequest) avm_readdata <= mem[avm_address[5:2]];
    if (avm_read || avm_write) bus_seen <= bus_seen + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle (T); returns in cycle T+1.
  task automatic start_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
    cpu_start = 1'b1;
    cpu_op    = op;
    cpu_addr  = addr;
    cpu_wdata = wd;
    tick();
    cpu_start = 1'b0;
  endtask

  task automatic do_store(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd);
    start_op(op, addr, wd);
    check_eq({tag, " write"}, 32'(avm_write), 32'd1);
    check_eq({tag, " be"}, 32'(avm_byteenable), 32'(exp_be));
    check_eq({tag, " wdata"}, avm_writedata, exp_wd);
    check_eq({tag, " addr"}, avm_address, {addr[31:2], 2'b00});
    tick();
    check_eq({tag, " done"}, {30'd0, cpu_err, cpu_done}, 32'd1);
    tick();
    check_eq({tag, " idle"}, {30'd0, cpu_busy, avm_write}, 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] rt, input logic [3:0] exp_be,
                         input logic [31:0] exp_rd);
    start_op(op, addr, rt);
    check_eq({tag, " read"}, 32'(avm_read), 32'd1);
    check_eq({tag, " be"}, 32'(avm_byteenable), 32'(exp_be));
    tick();
    check_eq({tag, " rdata-cycle"}, {30'd0, avm_read, cpu_done}, 32'd0);
    tick();
    check_eq({tag, " done"}, {30'd0, cpu_err, cpu_done}, 32'd1);
    check_eq({tag, " result"}, cpu_rdata, exp_rd);
    tick();
  endtask

  task automatic do_err(input string tag, input logic [3:0] op, input logic [31:0] addr);
    start_op(op, addr, 32'h1234_5678);
    check_eq({tag, " err+done"}, {30'd0, cpu_err, cpu_done}, 32'd3);
    check_eq({tag, " rdata"}, cpu_rdata, 32'd0);
    tick();
    check_eq({tag, " idle"}, {30'd0, cpu_busy, cpu_done}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    avm_readdata    = 32'd0;
    reset           = 1'b1;
    cpu_start       = 1'b0;
    cpu_op          = 4'd0;
    cpu_addr        = 32'd0;
    cpu_wdata       = 32'd0;
    avm_waitrequest = 1'b0;
    tick();
    tick();
    check_eq("reset ctl", {27'd0, cpu_busy, cpu_done, cpu_err, avm_read, avm_write}, 32'd0);
    check_eq("reset addr", avm_address, 32'd0);
    check_eq("reset rdata", cpu_rdata, 32'd0);
    check_eq("reset be/wd", avm_writedata | 32'(avm_byteenable), 32'd0);
    reset = 1'b0;
    tick();

    do_store("sw", 4'd10, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_load("lw", 4'd4, 32'h10, 32'h0, 4'b1111, 32'hDEAD_BEEF);

    do_store("sb", 4'd8, 32'h23, 32'h0000_0080, 4'b1000, 32'h8080_8080);
    do_load("lb", 4'd0, 32'h23, 32'h0, 4'b1000, 32'hFFFF_FF80);
    do_load("lbu", 4'd1, 32'h23, 32'h0, 4'b1000, 32'h0000_0080);

    do_store("sh", 4'd9, 32'h22, 32'h0000_8001, 4'b1100, 32'h8001_8001);
    do_load("lh", 4'd2, 32'h22, 32'h0, 4'b1100, 32'hFFFF_8001);
    do_load("lhu", 4'd3, 32'h22, 32'h0, 4'b1100, 32'h0000_8001);

    bus_seen = 0;
    do_err("lw mis", 4'd4, 32'h12);
    do_err("sh mis", 4'd9, 32'h11);
    do_err("illegal op", 4'd7, 32'h10);
`ifndef MEM_ACCESS_LWLR_EN
    do_err("lwl off", 4'd5, 32'h31);
    do_err("lwr off", 4'd6, 32'h31);
`endif
    check_eq("err no bus", bus_seen, 32'd0);

    do_store("sw2", 4'd10, 32'h30, 32'h4433_2211, 4'b1111, 32'h4433_2211);
`ifdef MEM_ACCESS_LWLR_EN
    do_load("lwl", 4'd5, 32'h31, 32'hAABB_CCDD, 4'b1111, 32'h2211_CCDD);
    do_load("lwr", 4'd6, 32'h31, 32'hAABB_CCDD, 4'b1111, 32'hAA44_3322);
`endif

    // Three stall cycles: request held T+1..T+4, done at T+6.
    avm_waitrequest = 1'b1;
    start_op(4'd4, 32'h10, 32'h0);
    for (int c = 0; c < 4; c++) begin
      check_eq("wait read held", {avm_read, avm_address[30:0]}, {1'b1, 31'h10});
      check_eq("wait be held", 32'(avm_byteenable), 32'hF);
      if (c == 3) avm_waitrequest = 1'b0;
      else tick();
    end
    tick();
    check_eq("wait rdata-cycle", {30'd0, avm_read, cpu_done}, 32'd0);
    tick();
    check_eq("wait done", 32'(cpu_done), 32'd1);
    check_eq("wait result", cpu_rdata, 32'hDEAD_BEEF);
    tick();

    // Reset while stalled: read drops next cycle and no done follows.
    avm_waitrequest = 1'b1;
    start_op(4'd4, 32'h10, 32'h0);
    check_eq("rst pre read", 32'(avm_read), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check_eq("rst read drop", {30'd0, avm_read, cpu_busy}, 32'd0);
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check_eq("rst no done", {30'd0, cpu_done, avm_read}, 32'd0);
      tick();
    end

    do_load("post rst lw", 4'd4, 32'h30, 32'h0, 4'b1111, 32'h4433_2211);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
